// File: rtl/pkg_opengpu.sv
// Shared SIMT core types and sizing constants.
// Used by the warp scheduler and the round-robin arbiters.
package pkg_opengpu;

    localparam int NUM_WARPS     = 4;
    localparam int WARP_ID_WIDTH = $clog2(NUM_WARPS);
    localparam int WARP_SIZE     = 32;
    localparam int ADDR_WIDTH    = 32;

    typedef enum logic [1:0] {
        W_IDLE     = 2'd0,
        W_READY    = 2'd1,
        W_INFLIGHT = 2'd2
    } warp_state_t;

endpackage

// File: rtl/simt_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
// N must be a power of two so the index arithmetic wraps naturally.
module simt_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id
);

    logic [IW-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ptr + IW'(i);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/simt_warp_scheduler.sv
// Round-robin SIMT warp scheduler: per-warp PC/mask/run state, one instruction in flight per warp.
// Optional performance counters are compiled in with SIMT_SCHED_PERF_EN.
//
// state      | meaning
// W_IDLE     | context free, may accept a launch
// W_READY    | eligible for issue to fetch
// W_INFLIGHT | one instruction issued, waiting for execute to resolve it
module simt_warp_scheduler
    import pkg_opengpu::*;
#(
    parameter int NUM_WARPS     = pkg_opengpu::NUM_WARPS,
    parameter int WARP_ID_WIDTH = $clog2(NUM_WARPS),
    parameter int WARP_SIZE     = pkg_opengpu::WARP_SIZE,
    parameter int ADDR_WIDTH    = pkg_opengpu::ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     launch_valid,
    input  logic [WARP_ID_WIDTH-1:0] launch_warp_id,
    input  logic [ADDR_WIDTH-1:0]    launch_pc,
    input  logic [WARP_SIZE-1:0]     launch_mask,
    output logic                     launch_ready,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [WARP_ID_WIDTH-1:0] issue_warp_id,
    output logic [ADDR_WIDTH-1:0]    issue_pc,
    output logic [WARP_SIZE-1:0]     issue_mask,
    input  logic                     resolve_valid,
    input  logic [WARP_ID_WIDTH-1:0] resolve_warp_id,
    input  logic [ADDR_WIDTH-1:0]    resolve_next_pc,
    input  logic [WARP_SIZE-1:0]     resolve_mask,
    input  logic                     resolve_done,
    output logic                     all_idle,
    output logic                     err
`ifdef SIMT_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_idle_cnt
`endif
);

    warp_state_t              state_q [NUM_WARPS];
    warp_state_t              state_d [NUM_WARPS];
    logic [ADDR_WIDTH-1:0]    pc_q    [NUM_WARPS];
    logic [ADDR_WIDTH-1:0]    pc_d    [NUM_WARPS];
    logic [WARP_SIZE-1:0]     mask_q  [NUM_WARPS];
    logic [WARP_SIZE-1:0]     mask_d  [NUM_WARPS];
    logic [WARP_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                     err_q, err_d;

    logic [NUM_WARPS-1:0]     ready_vec, idle_vec;
    logic                     grant_valid;
    logic [WARP_ID_WIDTH-1:0] grant_id;
    logic                     issue_fire, launch_fire;

    always_comb begin
        ready_vec = '0;
        idle_vec  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ready_vec[w] = (state_q[w] == W_READY);
            idle_vec[w]  = (state_q[w] == W_IDLE);
        end
    end

    simt_rr_arbiter #(
        .N  (NUM_WARPS),
        .IW (WARP_ID_WIDTH)
    ) u_arb (
        .req         (ready_vec),
        .ptr         (rr_ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign issue_valid   = grant_valid;
    assign issue_warp_id = grant_id;
    assign issue_pc      = pc_q[grant_id];
    assign issue_mask    = mask_q[grant_id];
    assign launch_ready  = idle_vec[launch_warp_id];
    assign all_idle      = &idle_vec;
    assign err           = err_q;
    assign issue_fire    = issue_valid && issue_ready;
    assign launch_fire   = launch_valid && launch_ready;

    // Launch, issue and resolve always hit distinct warps, so their updates never collide.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mask_d   = mask_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        if (launch_fire && (launch_mask != '0)) begin
            state_d[launch_warp_id] = W_READY;
            pc_d[launch_warp_id]    = launch_pc;
            mask_d[launch_warp_id]  = launch_mask;
        end
        if (issue_fire) begin
            state_d[grant_id] = W_INFLIGHT;
            rr_ptr_d          = grant_id;
        end
        if (resolve_valid) begin
            if (state_q[resolve_warp_id] == W_INFLIGHT) begin
                if (resolve_done || (resolve_mask == '0)) begin
                    state_d[resolve_warp_id] = W_IDLE;
                end else begin
                    state_d[resolve_warp_id] = W_READY;
                    pc_d[resolve_warp_id]    = resolve_next_pc;
                    mask_d[resolve_warp_id]  = resolve_mask;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w] <= W_IDLE;
                pc_q[w]    <= '0;
                mask_q[w]  <= '0;
            end
            rr_ptr_q <= WARP_ID_WIDTH'(NUM_WARPS - 1);
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            mask_q   <= mask_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

`ifdef SIMT_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_idle_cnt  <= '0;
        end else begin
            if (issue_fire && (perf_issue_cnt != '1))
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (issue_valid && !issue_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (!issue_valid && !all_idle && (perf_idle_cnt != '1))
                perf_idle_cnt <= perf_idle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simt_warp_scheduler.sv
// Directed bench for simt_warp_scheduler: reset, launch/issue/resolve, round-robin order, stalls, errors.
// Counter checks are included when SIMT_SCHED_PERF_EN is defined.
module tb_simt_warp_scheduler;

    localparam int WID = 2;
    localparam int WS  = 32;
    localparam int AW  = 32;

    logic           clk;
    logic           rst_n;
    logic           launch_valid;
    logic [WID-1:0] launch_warp_id;
    logic [AW-1:0]  launch_pc;
    logic [WS-1:0]  launch_mask;
    logic           launch_ready;
    logic           issue_valid;
    logic           issue_ready;
    logic [WID-1:0] issue_warp_id;
    logic [AW-1:0]  issue_pc;
    logic [WS-1:0]  issue_mask;
    logic           resolve_valid;
    logic [WID-1:0] resolve_warp_id;
    logic [AW-1:0]  resolve_next_pc;
    logic [WS-1:0]  resolve_mask;
    logic           resolve_done;
    logic           all_idle;
    logic           err;
`ifdef SIMT_SCHED_PERF_EN
    logic [31:0]    perf_issue_cnt, perf_stall_cnt, perf_idle_cnt;
    logic [31:0]    stall_base;
`endif

    int n_total = 0;
    int n_pass  = 0;

    simt_warp_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .launch_valid    (launch_valid),
        .launch_warp_id  (launch_warp_id),
        .launch_pc       (launch_pc),
        .launch_mask     (launch_mask),
        .launch_ready    (launch_ready),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_warp_id   (issue_warp_id),
        .issue_pc        (issue_pc),
        .issue_mask      (issue_mask),
        .resolve_valid   (resolve_valid),
        .resolve_warp_id (resolve_warp_id),
        .resolve_next_pc (resolve_next_pc),
        .resolve_mask    (resolve_mask),
        .resolve_done    (resolve_done),
        .all_idle        (all_idle),
        .err             (err)
`ifdef SIMT_SCHED_PERF_EN
        ,
        .perf_issue_cnt  (perf_issue_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_idle_cnt   (perf_idle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] base_pc(input int w);
        return 32'h1000 + 32'(w) * 32'h100;
    endfunction

    initial begin
        int            prev_w;
        logic [AW-1:0] prev_pc;
        int            exp_w;
        logic [AW-1:0] exp_pc;

        rst_n = 1'b0;
        launch_valid = 1'b0; launch_warp_id = '0; launch_pc = '0; launch_mask = '0;
        issue_ready = 1'b0;
        resolve_valid = 1'b0; resolve_warp_id = '0; resolve_next_pc = '0;
        resolve_mask = '0; resolve_done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_issue_valid", issue_valid, 0);
        check("rst_all_idle", all_idle, 1);
        check("rst_launch_ready", launch_ready, 1);
        check("rst_err", err, 0);

        // single launch of warp 2
        launch_valid = 1'b1; launch_warp_id = 2'd2; launch_pc = 32'h100; launch_mask = '1;
        #1 check("launch_ready_w2", launch_ready, 1);
        tick();
        launch_valid = 1'b0;
        check("l2_issue_valid", issue_valid, 1);
        check("l2_issue_id", issue_warp_id, 2);
        check("l2_issue_pc", issue_pc, 32'h100);
        check("l2_issue_mask", issue_mask, 32'hFFFF_FFFF);
        check("l2_all_idle", all_idle, 0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("l2_after_hs_valid", issue_valid, 0);
        check("l2_inflight_launch_ready", launch_ready, 0);

        // reset held across two edges mid-run
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("midrst_all_idle", all_idle, 1);
        check("midrst_issue_valid", issue_valid, 0);
        check("midrst_launch_ready_w2", launch_ready, 1);

        // launch all four warps back to back
        for (int w = 0; w < 4; w++) begin
            launch_valid = 1'b1; launch_warp_id = WID'(w); launch_pc = base_pc(w); launch_mask = '1;
            tick();
        end
        launch_valid = 1'b0;
        check("all_first_candidate", issue_warp_id, 0);

        // round-robin with each warp resolved the cycle after its issue
        prev_w = -1;
        prev_pc = '0;
        for (int i = 0; i < 5; i++) begin
            exp_w  = i % 4;
            exp_pc = base_pc(exp_w) + 32'(4 * (i / 4));
            issue_ready = 1'b1;
            if (prev_w >= 0) begin
                resolve_valid = 1'b1; resolve_warp_id = WID'(prev_w);
                resolve_next_pc = prev_pc + 32'd4; resolve_mask = '1; resolve_done = 1'b0;
            end else begin
                resolve_valid = 1'b0;
            end
            #1;
            check($sformatf("rr%0d_valid", i), issue_valid, 1);
            check($sformatf("rr%0d_id", i), issue_warp_id, exp_w);
            check($sformatf("rr%0d_pc", i), issue_pc, exp_pc);
            tick();
            prev_w  = exp_w;
            prev_pc = exp_pc;
        end

        // resolve warp 0 with a narrowed mask and a branch target
        issue_ready = 1'b0;
        resolve_valid = 1'b1; resolve_warp_id = 2'd0; resolve_next_pc = 32'h200;
        resolve_mask = 32'h0000_00FF; resolve_done = 1'b0;
        tick();
        resolve_valid = 1'b0;

`ifdef SIMT_SCHED_PERF_EN
        stall_base = perf_stall_cnt;
`endif
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_id", k), issue_warp_id, 1);
            check($sformatf("stall%0d_pc", k), issue_pc, base_pc(1) + 32'd4);
            check($sformatf("stall%0d_mask", k), issue_mask, 32'hFFFF_FFFF);
            tick();
        end
`ifdef SIMT_SCHED_PERF_EN
        check("perf_stall_delta", perf_stall_cnt - stall_base, 5);
`endif

        // drain: 1,2,3 then warp 0 with its resolved pc/mask
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_w  = (k + 1) % 4;
            exp_pc = (exp_w == 0) ? 32'h200 : base_pc(exp_w) + 32'd4;
            check($sformatf("drain%0d_id", k), issue_warp_id, exp_w);
            check($sformatf("drain%0d_pc", k), issue_pc, exp_pc);
            check($sformatf("drain%0d_mask", k), issue_mask,
                  (exp_w == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF);
            tick();
        end
        issue_ready = 1'b0;
        check("drain_all_inflight", issue_valid, 0);

        // retire warp 0 via RET
        resolve_valid = 1'b1; resolve_warp_id = 2'd0; resolve_done = 1'b1; resolve_mask = '1;
        tick();
        resolve_valid = 1'b0; resolve_done = 1'b0;
        launch_warp_id = 2'd0;
        #1 check("ret_w0_launch_ready", launch_ready, 1);
        check("ret_w0_err", err, 0);

        // retire warp 3 legally, then resolve it again while idle
        resolve_valid = 1'b1; resolve_warp_id = 2'd3; resolve_done = 1'b1;
        tick();
        check("ret_w3_err", err, 0);
        tick();
        resolve_valid = 1'b0; resolve_done = 1'b0;
        check("bad_resolve_err", err, 1);
        launch_warp_id = 2'd3;
        #1 check("bad_resolve_w3_idle", launch_ready, 1);
        tick(); tick();
        check("err_sticky", err, 1);

        // warp 1 back to READY with new pc/mask
        resolve_valid = 1'b1; resolve_warp_id = 2'd1; resolve_next_pc = 32'h300;
        resolve_mask = 32'h0000_F0F0; resolve_done = 1'b0;
        tick();
        resolve_valid = 1'b0;
        check("w1_ready_valid", issue_valid, 1);
        check("w1_ready_id", issue_warp_id, 1);
        check("w1_ready_pc", issue_pc, 32'h300);
        check("w1_ready_mask", issue_mask, 32'h0000_F0F0);

        // launch aimed at a READY warp is refused
        launch_valid = 1'b1; launch_warp_id = 2'd1; launch_pc = 32'hDEAD; launch_mask = '1;
        #1 check("busy_launch_ready", launch_ready, 0);
        tick();
        launch_valid = 1'b0;
        check("busy_launch_pc_kept", issue_pc, 32'h300);
        check("busy_launch_mask_kept", issue_mask, 32'h0000_F0F0);

        // zero-mask launch is accepted but leaves the warp idle
        launch_valid = 1'b1; launch_warp_id = 2'd3; launch_pc = 32'h400; launch_mask = '0;
        tick();
        launch_valid = 1'b0;
        #1 check("zero_mask_w3_idle", launch_ready, 1);
        check("zero_mask_no_issue", issue_warp_id, 1);

        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("final_issue_valid", issue_valid, 0);
        check("final_all_idle", all_idle, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simt_warp_scheduler.md
Name: simt_warp_scheduler

Overview:
- Round-robin warp scheduler in front of the SIMT fetch/decode pipeline.
- Owns per-warp PC, active mask and run state. Each cycle it selects one ready warp and presents warp_id/pc/mask to fetch.
- Allows one instruction in flight per warp. The warp is blocked from issue until execute resolves its next PC and mask.
- Warps are launched by the dispatch unit and retire on RET or an all-zero resolved mask.

Parameters:
- NUM_WARPS, 4, number of hardware warp contexts (power of two, ≥2).
- WARP_ID_WIDTH, $clog2(NUM_WARPS), warp index width.
- WARP_SIZE, 32, threads per warp (mask width).
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- launch_valid  in  1  dispatch requests a warp start.
- launch_warp_id  in  WARP_ID_WIDTH  target context.
- launch_pc  in  ADDR_WIDTH  start PC.
- launch_mask  in  WARP_SIZE  initial active mask.
- launch_ready  out  1  target context is IDLE; launch accepted when valid&&ready.
- issue_valid  out  1  a READY warp is selected.
- issue_ready  in  1  fetch can accept (driven as !stall by the pipeline).
- issue_warp_id  out  WARP_ID_WIDTH  selected warp.
- issue_pc  out  ADDR_WIDTH  selected warp PC.
- issue_mask  out  WARP_SIZE  selected warp active mask.
- resolve_valid  in  1  execute reports completion of a warp's in-flight instruction.
- resolve_warp_id  in  WARP_ID_WIDTH  warp being resolved.
- resolve_next_pc  in  ADDR_WIDTH  next PC (pc+4, branch or jump target).
- resolve_mask  in  WARP_SIZE  post-branch active mask.
- resolve_done  in  1  instruction was RET; retire the warp.
- all_idle  out  1  every context is IDLE.
- err  out  1  sticky: a resolve arrived for a warp not INFLIGHT.

Behaviour:
- Clocking and reset: one clock, synchronous active-low reset rst_n. All state updates on posedge clk; reset is sampled only at the edge.
- Reset values:
  - All warps IDLE; PCs and masks 0.
  - rr_ptr = NUM_WARPS-1, so warp 0 has first priority.
  - err=0; issue_valid=0; all_idle=1; launch_ready=1 (combinational from state).
- Per-warp state, 2-bit enum: W_IDLE, W_READY, W_INFLIGHT.
  - IDLE→READY on accepted launch: pc←launch_pc, mask←launch_mask. A launch with zero mask is accepted but the warp stays IDLE.
  - READY→INFLIGHT on issue handshake (issue_valid&&issue_ready) for that warp.
  - INFLIGHT→READY on resolve with resolve_done=0 and resolve_mask≠0: pc←resolve_next_pc, mask←resolve_mask.
  - INFLIGHT→IDLE on resolve with resolve_done=1 or resolve_mask==0.
  - Resolve for a warp not INFLIGHT: ignored, err←1 (cleared only by reset).
- Selection:
  - Purely combinational from registered state: first READY warp searching rr_ptr+1, rr_ptr+2, … with modulo-NUM_WARPS wrap-around.
  - issue_* outputs do not depend on issue_ready, resolve_* or launch_*.
  - On handshake, rr_ptr←issued warp id. Without a handshake rr_ptr holds and the outputs stay stable while stalled (no reselection unless state changes).
- Latency:
  - Launch to first possible issue: 1 cycle.
  - Resolve to re-eligibility: 1 cycle (the warp is READY the cycle after resolve).
- Simultaneous events:
  - Launch, issue and resolve in the same cycle target distinct warps by construction. Launch needs IDLE, issue needs READY, resolve needs INFLIGHT, and all are evaluated on pre-edge state, so all apply.
  - Resolve of warp A while A is the issue candidate is impossible, since A is INFLIGHT and not READY.
- Fairness: with all warps READY and issue_ready=1, issue order is 0,1,2,3,0,… provided resolves return in time.

Optional Feature:
- Macro: SIMT_SCHED_PERF_EN.
- When defined, add:
  - output perf_issue_cnt [31:0]: counts handshakes.
  - output perf_stall_cnt [31:0]: counts cycles with issue_valid&&!issue_ready.
  - output perf_idle_cnt [31:0]: counts cycles with !issue_valid && !all_idle.
- All counters are reset to 0 by rst_n and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- pkg_opengpu gains:
  - typedef enum logic [1:0] warp_state_t {W_IDLE, W_READY, W_INFLIGHT}.
  - NUM_WARPS.
  - Existing WARP_ID_WIDTH, WARP_SIZE and ADDR_WIDTH are reused from there.
- One sub-module: simt_rr_arbiter (parameter N).
  - Inputs: req[N-1:0], ptr.
  - Outputs: grant_valid, grant_id.
  - Purely combinational; reusable for the LSU and FPU arbiters.

Test Plan:
- Reset then idle → issue_valid=0, all_idle=1, launch_ready=1, err=0; holding rst_n=0 across two edges mid-run returns all warps to IDLE.
- Launch warp 2 at pc=0x100, mask=0xFFFF_FFFF → next cycle issue_valid=1, issue_warp_id=2, issue_pc=0x100; with no resolve, issue_valid=0 after the handshake.
- Launch warps 0–3, issue_ready=1, each resolved 1 cycle after issue with next_pc=pc+4 → issue sequence 0,1,2,3,0 with PCs incrementing by 4 per warp.
- Warp 1 selected with issue_ready=0 for 5 cycles → issue_warp_id/pc/mask held constant; with SIMT_SCHED_PERF_EN, perf_stall_cnt=5.
- Resolve warp 0 with resolve_mask=0x0000_00FF, next_pc=0x200 → next issue of warp 0 shows mask 0x0000_00FF, pc 0x200. A subsequent resolve_done=1 → warp 0 IDLE, launch_ready=1 for id 0.
- Resolve warp 3 while it is IDLE → err=1 and stays 1; warp 3 state unchanged; a launch to a READY warp keeps launch_ready=0 and the warp's PC unchanged.
